// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer: requester count,
// index width, counter widths, FSM state type and pointer-advance helper.
package rr_grant_sequencer_pkg;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned GAP_CNT_W  = 4;
    localparam int unsigned HOLD_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } rr_state_e;

    // Rotation pointer after a release: the owner's successor, wrapping 3 -> 0,
    // which leaves the released owner ranked lowest in the next pick.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_grant_sequencer_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
// Rotates req so ptr lands at bit 0, takes the lowest set bit, then adds ptr
// back to recover the absolute requester index.
module rr_pick4
    import rr_grant_sequencer_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_pos;
    logic [IDX_W-1:0]   w_off;
    logic               w_found;

    // Rotate, fixed-priority scan from bit 0, un-rotate.
    always_comb begin
        w_rot   = '0;
        w_pos   = '0;
        w_off   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pos    = IDX_W'(i) + ptr;
            w_rot[i] = req[w_pos];
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_rot[i] && !w_found) begin
                w_found = 1'b1;
                w_off   = IDX_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = w_off + ptr;

endmodule

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: four-way round-robin arbiter driving a 2-to-4 tristate
// decoder (grant_idx -> I, grant_valid -> Enable). A grant is held until the
// owner releases it, then GAP_CYCLES dead cycles separate it from the next
// grant so decoder outputs never overlap on handover.
// Optional feature: define RR_TIMEOUT_EN to force-release a grant after
// HOLD_MAX cycles, pulsing timeout on the first dead cycle.
module rr_grant_sequencer
    import rr_grant_sequencer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned HOLD_MAX   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("rr_grant_sequencer: GAP_CYCLES must be 1..15");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_grant_sequencer: HOLD_MAX must be 2..255");
    end

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);

    rr_state_e             r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [GAP_CNT_W-1:0]  r_gap_cnt;
    logic [IDX_W-1:0]      r_grant_idx;
    logic                  r_grant_valid;
    logic                  r_timeout;

    logic                  w_pick_any;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_owner_req;
    logic                  w_hold_expired;
    logic                  w_forced;
    logic                  w_release;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    assign w_owner_req = req[r_grant_idx];

`ifdef RR_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

    logic [HOLD_CNT_W-1:0] r_hold_cnt;

    // Hold counter: zero outside GRANT so every grant starts from 0, saturating count inside.
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_GRANT) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign w_hold_expired = (r_hold_cnt == HOLD_LAST);
    // A revoke counts as forced only when the owner was not releasing anyway.
    assign w_forced       = w_hold_expired && !done && w_owner_req;
`else
    assign w_hold_expired = 1'b0;
    assign w_forced       = 1'b0;
`endif

    assign w_release = done || !w_owner_req || w_hold_expired;

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_gap_cnt     <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_grant_valid <= 1'b0;
                    if (w_pick_any) begin
                        r_state       <= ST_GRANT;
                        r_grant_idx   <= w_pick_idx;
                        r_grant_valid <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state       <= ST_GAP;
                        r_grant_valid <= 1'b0;
                        r_ptr         <= next_ptr(r_grant_idx);
                        r_gap_cnt     <= '0;
                        r_timeout     <= w_forced;
                    end
                end
                ST_GAP: begin
                    r_grant_valid <= 1'b0;
                    if (r_gap_cnt == GAP_LAST) begin
                        if (w_pick_any) begin
                            r_state       <= ST_GRANT;
                            r_grant_idx   <= w_pick_idx;
                            r_grant_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_gap_cnt != '1) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
